// File: rtl/pdm_pkg.sv
`timescale 1ns/1ps
// Shared widths, feedback constants, state type and saturation helpers for
// the PDM microphone emulator and its capture-side companions.
package pdm_pkg;

  localparam int unsigned PCM_W  = 16;
  localparam int unsigned INT1_W = 20;
  localparam int unsigned INT2_W = 24;

  localparam logic signed [PCM_W-1:0] FB_POS = 16'sh7FFF;
  localparam logic signed [PCM_W-1:0] FB_NEG = 16'sh8000;

  typedef enum logic {
    SLEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Clamp a two-bit-wider sum into the first integrator's range.
  function automatic logic signed [INT1_W-1:0] sat_int1(input logic [INT1_W+1:0] v);
    if (v[INT1_W+1:INT1_W-1] == 3'b000 || v[INT1_W+1:INT1_W-1] == 3'b111)
      return v[INT1_W-1:0];
    else if (v[INT1_W+1])
      return {1'b1, {(INT1_W-1){1'b0}}};
    else
      return {1'b0, {(INT1_W-1){1'b1}}};
  endfunction

  // Clamp a two-bit-wider sum into the second integrator's range.
  function automatic logic signed [INT2_W-1:0] sat_int2(input logic [INT2_W+1:0] v);
    if (v[INT2_W+1:INT2_W-1] == 3'b000 || v[INT2_W+1:INT2_W-1] == 3'b111)
      return v[INT2_W-1:0];
    else if (v[INT2_W+1])
      return {1'b1, {(INT2_W-1){1'b0}}};
    else
      return {1'b0, {(INT2_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
`timescale 1ns/1ps
// Two-flop synchronizer for an asynchronous clock-like input, followed by
// registered one-cycle rise/fall pulses in the clk domain.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_det,
  output logic fall_det
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic rise_q,  rise_d;
  logic fall_q,  fall_d;

  // Next-state: shift the pin through the synchronizer and compare stages.
  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_d  = sync2_q & ~prev_q;
    fall_d  = ~sync2_q & prev_q;
  end

  // Synchronizer, edge-detect and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign rise_det = rise_q;
  assign fall_det = fall_q;

endmodule

// File: rtl/pdm_mic_emulator.sv
`timescale 1ns/1ps
// PDM microphone stand-in: second-order sigma-delta modulation of host PCM
// samples, clocked by the externally supplied mic clock, with a one-deep
// sample hold register and an idle-timeout sleep state.
module pdm_mic_emulator
  import pdm_pkg::*;
#(
  parameter int unsigned CHANNEL     = 0,
  parameter int unsigned DECIM       = 64,
  parameter int unsigned IDLE_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mic_clk,
  input  logic [PCM_W-1:0]  sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              pdm_out,
  output logic              pdm_oe,
  output logic              underrun
);

  localparam int unsigned      DEC_W     = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DEC_W-1:0] DEC_LAST  = DEC_W'(DECIM - 1);
  localparam logic [7:0]       IDLE_LAST = 8'(IDLE_CYCLES - 1);

  logic rise_det, fall_det, launch_det, release_det, any_edge;
  logic consume, accept;

  state_e                    state_q, state_d;
  logic [7:0]                idle_q, idle_d;
  logic signed [INT1_W-1:0]  int1_q, int1_d, int1_new;
  logic signed [INT2_W-1:0]  int2_q, int2_d, int2_new;
  logic signed [PCM_W-1:0]   x_q, x_d, fb;
  logic [PCM_W-1:0]          hold_q, hold_d;
  logic                      full_q, full_d;
  logic [DEC_W-1:0]          dec_q, dec_d;
  logic                      pdm_out_q, pdm_out_d;
  logic                      pdm_oe_q, pdm_oe_d;
  logic                      underrun_q, underrun_d;

  sync_edge_detect u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (mic_clk),
    .rise_det (rise_det),
    .fall_det (fall_det)
  );

  assign launch_det  = (CHANNEL != 0) ? rise_det : fall_det;
  assign release_det = (CHANNEL != 0) ? fall_det : rise_det;
  assign any_edge    = rise_det | fall_det;

  // Consume depends only on registered state so ready/accept stay loop-free.
  assign consume      = launch_det && (dec_q == DEC_LAST) && full_q;
  assign sample_ready = !full_q || consume;
  assign accept       = sample_valid && sample_ready;

  // Modulator step from current state; committed only on a launch edge.
  always_comb begin
    fb = pdm_out_q ? FB_POS : FB_NEG;
    int1_new = sat_int1({{2{int1_q[INT1_W-1]}}, int1_q}
                      + {{(INT1_W+2-PCM_W){x_q[PCM_W-1]}}, x_q}
                      - {{(INT1_W+2-PCM_W){fb[PCM_W-1]}}, fb});
    int2_new = sat_int2({{2{int2_q[INT2_W-1]}}, int2_q}
                      + {{(INT2_W+2-INT1_W){int1_new[INT1_W-1]}}, int1_new}
                      - {{(INT2_W+2-PCM_W){fb[PCM_W-1]}}, fb});
  end

  // Sleep/run control, launch/release handling and sample hold register.
  always_comb begin
    state_d    = state_q;
    idle_d     = idle_q;
    int1_d     = int1_q;
    int2_d     = int2_q;
    x_d        = x_q;
    hold_d     = hold_q;
    full_d     = full_q;
    dec_d      = dec_q;
    pdm_out_d  = pdm_out_q;
    pdm_oe_d   = pdm_oe_q;
    underrun_d = 1'b0;

    // A wake-up edge is handled exactly like an edge seen while running.
    if (state_q == RUN || any_edge) begin
      state_d = RUN;
      if (any_edge) begin
        idle_d = '0;
      end else if (idle_q == IDLE_LAST) begin
        state_d   = SLEEP;
        idle_d    = '0;
        int1_d    = '0;
        int2_d    = '0;
        pdm_out_d = 1'b0;
        pdm_oe_d  = 1'b0;
      end else begin
        idle_d = idle_q + 8'd1;
      end

      if (launch_det) begin
        int1_d    = int1_new;
        int2_d    = int2_new;
        pdm_out_d = ~int2_new[INT2_W-1];
        pdm_oe_d  = 1'b1;
        if (dec_q == DEC_LAST) begin
          dec_d = '0;
          if (full_q) begin
            x_d    = hold_q;
            full_d = 1'b0;
          end else begin
            underrun_d = 1'b1;
          end
        end else begin
          dec_d = dec_q + 1'b1;
        end
      end

      if (release_det)
        pdm_oe_d = 1'b0;
    end

    if (accept) begin
      hold_d = sample_in;
      full_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SLEEP;
      idle_q     <= '0;
      int1_q     <= '0;
      int2_q     <= '0;
      x_q        <= '0;
      hold_q     <= '0;
      full_q     <= 1'b0;
      dec_q      <= '0;
      pdm_out_q  <= 1'b0;
      pdm_oe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_q     <= idle_d;
      int1_q     <= int1_d;
      int2_q     <= int2_d;
      x_q        <= x_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      dec_q      <= dec_d;
      pdm_out_q  <= pdm_out_d;
      pdm_oe_q   <= pdm_oe_d;
      underrun_q <= underrun_d;
    end
  end

  assign pdm_out  = pdm_out_q;
  assign pdm_oe   = pdm_oe_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_pdm_mic_emulator.sv
`timescale 1ns/1ps
// Directed bench: left-channel instance (DECIM=64) for reset, sleep,
// hold-register and density scenarios; right-channel instance (DECIM=2)
// for launch/release latency and integrator saturation.
module tb_pdm_mic_emulator;
  import pdm_pkg::*;

  localparam int HALF = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mic_clk0 = 1'b0;
  logic        mic_clk1 = 1'b0;
  logic [15:0] sample_in0 = '0;
  logic [15:0] sample_in1 = '0;
  logic        sample_valid0 = 1'b0;
  logic        sample_valid1 = 1'b0;
  logic        sample_ready0, pdm_out0, pdm_oe0, underrun0;
  logic        sample_ready1, pdm_out1, pdm_oe1, underrun1;

  int checks = 0;
  int errors = 0;
  int launch_idx = 0;
  int ur_cnt = 0;
  int ur_last = 0;

  pdm_mic_emulator #(.CHANNEL(0), .DECIM(64), .IDLE_CYCLES(255)) dut0 (
    .clk(clk), .rst(rst), .mic_clk(mic_clk0),
    .sample_in(sample_in0), .sample_valid(sample_valid0), .sample_ready(sample_ready0),
    .pdm_out(pdm_out0), .pdm_oe(pdm_oe0), .underrun(underrun0)
  );

  pdm_mic_emulator #(.CHANNEL(1), .DECIM(2), .IDLE_CYCLES(255)) dut1 (
    .clk(clk), .rst(rst), .mic_clk(mic_clk1),
    .sample_in(sample_in1), .sample_valid(sample_valid1), .sample_ready(sample_ready1),
    .pdm_out(pdm_out1), .pdm_oe(pdm_oe1), .underrun(underrun1)
  );

  initial forever #10 clk = ~clk;

  // Underrun pulse monitor for the left-channel instance.
  initial forever begin
    @(negedge clk);
    if (underrun0 === 1'b1) begin
      ur_cnt++;
      ur_last = launch_idx;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One left-channel mic period; samples the bit launched by the previous fall.
  task automatic mic_period0(output logic b, output logic oe);
    repeat (HALF) @(posedge clk);
    #1;
    b  = pdm_out0;
    oe = pdm_oe0;
    mic_clk0 = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    mic_clk0 = 1'b0;
    launch_idx++;
  endtask

  task automatic run0(input int n, output int ones);
    logic b, oe;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      mic_period0(b, oe);
      if (b === 1'b1) ones++;
    end
  endtask

  task automatic mic_period1(output logic b);
    repeat (HALF) @(posedge clk);
    #1;
    b = pdm_out1;
    mic_clk1 = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    mic_clk1 = 1'b0;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1;
    rst = 1'b1;
    sample_valid0 = 1'b0;
    sample_valid1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    launch_idx = 0;
  endtask

  task automatic test_reset;
    logic b, oe;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      mic_clk0 = ~mic_clk0;
      checks++;
      if (pdm_oe0 !== 1'b0 || pdm_out0 !== 1'b0 || sample_ready0 !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: oe=%b out=%b ready=%b, want 0 0 1", i, pdm_oe0, pdm_out0, sample_ready0);
      end
    end
    rst = 1'b0;
    launch_idx = 0;
    mic_period0(b, oe);
    checks++;
    if (oe !== 1'b0) begin errors++; $display("FAIL reset_pre_launch_oe: got %b want 0", oe); end
    mic_period0(b, oe);
    checks++;
    if (oe !== 1'b1 || b !== 1'b1) begin
      errors++; $display("FAIL reset_first_launch: oe=%b out=%b want 1 1", oe, b);
    end
  endtask

  task automatic test_sleep;
    logic b, oe;
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (dut0.state_q !== RUN || pdm_oe0 !== 1'b1) begin
      errors++; $display("FAIL sleep_still_run: state=%0d oe=%b want 1 1", dut0.state_q, pdm_oe0);
    end
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (dut0.state_q !== SLEEP || pdm_oe0 !== 1'b0 || pdm_out0 !== 1'b0 ||
        dut0.int1_q !== 20'sd0 || dut0.int2_q !== 24'sd0) begin
      errors++;
      $display("FAIL sleep_entered: state=%0d oe=%b out=%b int1=%0d int2=%0d want 0 0 0 0 0",
               dut0.state_q, pdm_oe0, pdm_out0, dut0.int1_q, dut0.int2_q);
    end
    mic_period0(b, oe);
    mic_period0(b, oe);
    checks++;
    if (b !== 1'b1 || oe !== 1'b1) begin errors++; $display("FAIL wake_bit1: out=%b oe=%b want 1 1", b, oe); end
    mic_period0(b, oe);
    checks++;
    if (b !== 1'b1) begin errors++; $display("FAIL wake_bit2: got %b want 1", b); end
    mic_period0(b, oe);
    checks++;
    if (b !== 1'b0) begin errors++; $display("FAIL wake_bit3: got %b want 0", b); end
  endtask

  task automatic test_channel1;
    @(posedge clk); #1; mic_clk1 = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (pdm_out1 !== 1'b0 || pdm_oe1 !== 1'b0) begin
      errors++; $display("FAIL ch1_rise_early: out=%b oe=%b want 0 0", pdm_out1, pdm_oe1);
    end
    @(posedge clk); #1;
    checks++;
    if (pdm_out1 !== 1'b1 || pdm_oe1 !== 1'b1) begin
      errors++; $display("FAIL ch1_rise_4clk: out=%b oe=%b want 1 1", pdm_out1, pdm_oe1);
    end
    repeat (6) @(posedge clk); #1; mic_clk1 = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (pdm_oe1 !== 1'b1) begin errors++; $display("FAIL ch1_fall_early: oe=%b want 1", pdm_oe1); end
    @(posedge clk); #1;
    checks++;
    if (pdm_oe1 !== 1'b0 || pdm_out1 !== 1'b1) begin
      errors++; $display("FAIL ch1_fall_4clk: oe=%b out=%b want 0 1", pdm_oe1, pdm_out1);
    end
    repeat (6) @(posedge clk); #1; mic_clk1 = 1'b1;
    repeat (10) @(posedge clk); #1; mic_clk1 = 1'b0;
    repeat (10) @(posedge clk); #1; mic_clk1 = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (pdm_out1 !== 1'b1) begin errors++; $display("FAIL ch1_bit3_early: out=%b want 1", pdm_out1); end
    @(posedge clk); #1;
    checks++;
    if (pdm_out1 !== 1'b0) begin errors++; $display("FAIL ch1_bit3_4clk: out=%b want 0", pdm_out1); end
    repeat (6) @(posedge clk); #1; mic_clk1 = 1'b0;
  endtask

  task automatic test_underrun;
    int ones, base;
    do_reset();
    sample_in0 = 16'd1000;
    sample_valid0 = 1'b1;
    @(posedge clk); #1;
    sample_valid0 = 1'b0;
    checks++;
    if (sample_ready0 !== 1'b0) begin errors++; $display("FAIL ready_after_accept: got %b want 0", sample_ready0); end
    base = ur_cnt;
    run0(130, ones);
    checks++;
    if (ur_cnt - base !== 1 || ur_last !== 128) begin
      errors++; $display("FAIL underrun_first: pulses=%0d at launch %0d, want 1 at 128", ur_cnt - base, ur_last);
    end
    checks++;
    if (dut0.x_q !== 16'sd1000 || sample_ready0 !== 1'b1) begin
      errors++; $display("FAIL consume_x: x=%0d ready=%b want 1000 1", dut0.x_q, sample_ready0);
    end
    run0(130, ones);
    checks++;
    if (ur_cnt - base !== 3 || ur_last !== 256) begin
      errors++; $display("FAIL underrun_period: pulses=%0d last launch %0d, want 3 at 256", ur_cnt - base, ur_last);
    end
    checks++;
    if (dut0.x_q !== 16'sd1000) begin errors++; $display("FAIL underrun_x_kept: x=%0d want 1000", dut0.x_q); end
  endtask

  task automatic test_consume_accept;
    int ones, base;
    do_reset();
    sample_in0 = 16'd1234;
    sample_valid0 = 1'b1;
    @(posedge clk); #1;
    sample_valid0 = 1'b0;
    base = ur_cnt;
    run0(63, ones);
    repeat (HALF) @(posedge clk); #1; mic_clk0 = 1'b1;
    repeat (HALF) @(posedge clk); #1; mic_clk0 = 1'b0;
    launch_idx++;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (sample_ready0 !== 1'b0) begin errors++; $display("FAIL ready_before_consume: got %b want 0", sample_ready0); end
    @(posedge clk); #1;
    checks++;
    if (sample_ready0 !== 1'b1) begin errors++; $display("FAIL ready_on_consume: got %b want 1", sample_ready0); end
    sample_in0 = 16'd4321;
    sample_valid0 = 1'b1;
    @(posedge clk); #1;
    sample_valid0 = 1'b0;
    checks++;
    if (sample_ready0 !== 1'b0 || dut0.x_q !== 16'sd1234) begin
      errors++; $display("FAIL accept_on_consume: ready=%b x=%0d want 0 1234", sample_ready0, dut0.x_q);
    end
    run0(65, ones);
    checks++;
    if (dut0.x_q !== 16'sd4321 || sample_ready0 !== 1'b1 || ur_cnt !== base) begin
      errors++; $display("FAIL second_consume: x=%0d ready=%b underruns=%0d want 4321 1 0", dut0.x_q, sample_ready0, ur_cnt - base);
    end
  endtask

  task automatic test_density(input logic [15:0] s, input int lo, input int hi);
    int ones, base;
    do_reset();
    sample_in0 = s;
    sample_valid0 = 1'b1;
    run0(150, ones);
    base = ur_cnt;
    run0(1024, ones);
    checks++;
    if (ones < lo || ones > hi || ur_cnt !== base) begin
      errors++; $display("FAIL density x=%0d: ones=%0d underruns=%0d want %0d..%0d and 0", $signed(s), ones, ur_cnt - base, lo, hi);
    end
    sample_valid0 = 1'b0;
  endtask

  task automatic test_saturate;
    logic b;
    int ones;
    do_reset();
    sample_in1 = 16'h8000;
    sample_valid1 = 1'b1;
    for (int i = 0; i < 300; i++) mic_period1(b);
    checks++;
    if (dut1.int2_q !== 24'sh800000 || dut1.int1_q !== -20'sd65534) begin
      errors++; $display("FAIL saturate_int: int1=%0d int2=%0d want -65534 -8388608", dut1.int1_q, dut1.int2_q);
    end
    ones = 0;
    for (int i = 0; i < 32; i++) begin
      mic_period1(b);
      if (b !== 1'b0) ones++;
    end
    checks++;
    if (ones !== 0 || dut1.int2_q !== 24'sh800000) begin
      errors++; $display("FAIL saturate_hold: nonzero bits=%0d int2=%0d want 0 -8388608", ones, dut1.int2_q);
    end
    sample_valid1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sleep();
    test_channel1();
    test_underrun();
    test_consume_accept();
    test_density(16'd0, 510, 514);
    test_density(16'd16384, 760, 776);
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
